// File: rtl/bcpu_defs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcpu_defs (package)
//  Description : Shared grant encodings, host FSM states and slice helper
//                for the BCPU16 output bus arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package bcpu_defs;

    localparam logic GRANT_CPU  = 1'b0;
    localparam logic GRANT_HOST = 1'b1;

    typedef enum logic [0:0] {
        H_EMPTY = 1'b0,
        H_PEND  = 1'b1
    } host_state_t;

    function automatic int obus_slices(input int obus_bits, input int data_width);
        return (obus_bits + data_width - 1) / data_width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcpu_obus_slice_wr.sv
`default_nettype none
// ============================================================================
//  Module      : bcpu_obus_slice_wr
//  Description : Combinational masked update of one output bus slice.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcpu_obus_slice_wr #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_cur,
    input  logic [WIDTH-1:0] i_data,
    input  logic [WIDTH-1:0] i_mask,
    input  logic             i_we,
    output logic [WIDTH-1:0] o_nxt
);

    assign o_nxt = i_we ? ((i_cur & ~i_mask) | (i_data & i_mask)) : i_cur;

endmodule
`default_nettype wire

// File: rtl/bcpu_obus_arb.sv
`default_nettype none
// ============================================================================
//  Module      : bcpu_obus_arb
//  Description : OBUS register with round-robin shared write path between the
//                barrel pipeline OUT instruction and a host config port.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcpu_obus_arb
    import bcpu_defs::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int BUS_ADDR_WIDTH = 3,
    parameter int OBUS_BITS      = 4
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      CE,
    input  logic                      CPU_WR_EN,
    input  logic [BUS_ADDR_WIDTH-1:0] CPU_ADDR,
    input  logic [DATA_WIDTH-1:0]     CPU_DATA,
    input  logic [DATA_WIDTH-1:0]     CPU_MASK,
    output logic                      WAIT_REQUEST,
    input  logic                      HOST_VALID,
    output logic                      HOST_READY,
    input  logic [BUS_ADDR_WIDTH-1:0] HOST_ADDR,
    input  logic [DATA_WIDTH-1:0]     HOST_DATA,
    input  logic [DATA_WIDTH-1:0]     HOST_MASK,
    output logic [OBUS_BITS-1:0]      OBUS
);

    localparam int c_nslices = obus_slices(OBUS_BITS, DATA_WIDTH);
    localparam int c_last_w  = OBUS_BITS - (c_nslices - 1) * DATA_WIDTH;

    host_state_t               r_hstate;
    host_state_t               w_hstate_nxt;
    logic [BUS_ADDR_WIDTH-1:0] r_hbuf_addr;
    logic [DATA_WIDTH-1:0]     r_hbuf_data;
    logic [DATA_WIDTH-1:0]     r_hbuf_mask;
    logic                      r_last_grant;
    logic [OBUS_BITS-1:0]      r_obus;

    logic w_cpu_req;
    logic w_host_req;
    logic w_cpu_oor;
    logic w_host_oor;
    logic w_same_slice;
    logic w_conflict;
    logic w_cpu_gnt;
    logic w_host_gnt;
    logic w_host_accept;

    wire logic [OBUS_BITS-1:0] w_host_nxt;
    wire logic [OBUS_BITS-1:0] w_obus_nxt;

    assign w_cpu_req     = CE & CPU_WR_EN;
    assign w_host_req    = (r_hstate == H_PEND);
    assign w_host_accept = HOST_VALID & (r_hstate == H_EMPTY);

    // All out-of-range addresses alias to one virtual no-op slice.
    assign w_cpu_oor    = (int'(CPU_ADDR) >= c_nslices);
    assign w_host_oor   = (int'(r_hbuf_addr) >= c_nslices);
    assign w_same_slice = (w_cpu_oor & w_host_oor) | (CPU_ADDR == r_hbuf_addr);
    assign w_conflict   = w_cpu_req & w_host_req & w_same_slice;

    assign w_cpu_gnt  = w_cpu_req  & (~w_conflict | (r_last_grant == GRANT_HOST));
    assign w_host_gnt = w_host_req & (~w_conflict | (r_last_grant == GRANT_CPU));

    assign WAIT_REQUEST = w_cpu_req & ~w_cpu_gnt;
    assign HOST_READY   = (r_hstate == H_EMPTY);
    assign OBUS         = r_obus;

    always_comb begin
        w_hstate_nxt = r_hstate;
        case (r_hstate)
            H_EMPTY: if (HOST_VALID) w_hstate_nxt = H_PEND;
            H_PEND:  if (w_host_gnt) w_hstate_nxt = H_EMPTY;
            default: w_hstate_nxt = H_EMPTY;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_hstate <= H_EMPTY;
        end else begin
            r_hstate <= w_hstate_nxt;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_hbuf_addr  <= '0;
            r_hbuf_data  <= '0;
            r_hbuf_mask  <= '0;
            r_last_grant <= GRANT_HOST;
            r_obus       <= '0;
        end else begin
            if (w_host_accept) begin
                r_hbuf_addr <= HOST_ADDR;
                r_hbuf_data <= HOST_DATA;
                r_hbuf_mask <= HOST_MASK;
            end
            // A dual grant to different slices leaves the rotation alone.
            if (w_cpu_gnt && !w_host_gnt) begin
                r_last_grant <= GRANT_CPU;
            end else if (w_host_gnt && !w_cpu_gnt) begin
                r_last_grant <= GRANT_HOST;
            end
            r_obus <= w_obus_nxt;
        end
    end

    // Host update first, CPU second; both only meet in one slice when the
    // arbiter has already picked a single winner.
    for (genvar gi = 0; gi < c_nslices; gi++) begin : g_slice
        localparam int c_lo = gi * DATA_WIDTH;
        localparam int c_w  = (gi == c_nslices - 1) ? c_last_w : DATA_WIDTH;

        logic w_host_we;
        logic w_cpu_we;

        assign w_host_we = w_host_gnt & (int'(r_hbuf_addr) == gi);
        assign w_cpu_we  = w_cpu_gnt  & (int'(CPU_ADDR) == gi);

        bcpu_obus_slice_wr #(
            .WIDTH (c_w)
        ) u_host_wr (
            .i_cur  (r_obus[c_lo +: c_w]),
            .i_data (r_hbuf_data[c_w-1:0]),
            .i_mask (r_hbuf_mask[c_w-1:0]),
            .i_we   (w_host_we),
            .o_nxt  (w_host_nxt[c_lo +: c_w])
        );

        bcpu_obus_slice_wr #(
            .WIDTH (c_w)
        ) u_cpu_wr (
            .i_cur  (w_host_nxt[c_lo +: c_w]),
            .i_data (CPU_DATA[c_w-1:0]),
            .i_mask (CPU_MASK[c_w-1:0]),
            .i_we   (w_cpu_we),
            .o_nxt  (w_obus_nxt[c_lo +: c_w])
        );
    end

    // Data/mask bits above a partial last slice are intentionally dropped.
    if (c_last_w < DATA_WIDTH) begin : g_partial
        wire logic w_unused_hi = ^{CPU_DATA[DATA_WIDTH-1:c_last_w],
                                   CPU_MASK[DATA_WIDTH-1:c_last_w],
                                   r_hbuf_data[DATA_WIDTH-1:c_last_w],
                                   r_hbuf_mask[DATA_WIDTH-1:c_last_w]};
    end

endmodule
`default_nettype wire

// File: tb/tb_bcpu_obus_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcpu_obus_arb
//  Description : Scoreboard bench for bcpu_obus_arb with a 20-bit OBUS.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcpu_obus_arb;

    localparam int c_dw = 16;
    localparam int c_aw = 3;
    localparam int c_ob = 20;

    localparam int K_OBUS  = 0;
    localparam int K_READY = 1;
    localparam int K_WAIT  = 2;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              CE;
    logic              CPU_WR_EN;
    logic [c_aw-1:0]   CPU_ADDR;
    logic [c_dw-1:0]   CPU_DATA;
    logic [c_dw-1:0]   CPU_MASK;
    logic              WAIT_REQUEST;
    logic              HOST_VALID;
    logic              HOST_READY;
    logic [c_aw-1:0]   HOST_ADDR;
    logic [c_dw-1:0]   HOST_DATA;
    logic [c_dw-1:0]   HOST_MASK;
    logic [c_ob-1:0]   OBUS;

    typedef struct {
        int          kind;
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 CLK = ~CLK;

    bcpu_obus_arb #(
        .DATA_WIDTH     (c_dw),
        .BUS_ADDR_WIDTH (c_aw),
        .OBUS_BITS      (c_ob)
    ) u_dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .CE           (CE),
        .CPU_WR_EN    (CPU_WR_EN),
        .CPU_ADDR     (CPU_ADDR),
        .CPU_DATA     (CPU_DATA),
        .CPU_MASK     (CPU_MASK),
        .WAIT_REQUEST (WAIT_REQUEST),
        .HOST_VALID   (HOST_VALID),
        .HOST_READY   (HOST_READY),
        .HOST_ADDR    (HOST_ADDR),
        .HOST_DATA    (HOST_DATA),
        .HOST_MASK    (HOST_MASK),
        .OBUS         (OBUS)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_val(input int kind, input string tag, input logic [31:0] val);
        exp_t e;
        e.kind = kind;
        e.tag  = tag;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] got;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.kind)
                K_OBUS:  got = {12'h0, OBUS};
                K_READY: got = {31'h0, HOST_READY};
                default: got = {31'h0, WAIT_REQUEST};
            endcase
            check_val(e.tag, got, e.val);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic cpu_set(input logic ce, input logic wr, input logic [c_aw-1:0] a,
                           input logic [c_dw-1:0] d, input logic [c_dw-1:0] m);
        CE = ce; CPU_WR_EN = wr; CPU_ADDR = a; CPU_DATA = d; CPU_MASK = m;
    endtask

    task automatic host_set(input logic v, input logic [c_aw-1:0] a,
                            input logic [c_dw-1:0] d, input logic [c_dw-1:0] m);
        HOST_VALID = v; HOST_ADDR = a; HOST_DATA = d; HOST_MASK = m;
    endtask

    task automatic cpu_idle();
        cpu_set(1'b1, 1'b0, '0, '0, '0);
    endtask

    task automatic host_idle();
        host_set(1'b0, '0, '0, '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET = 1'b1;
        cpu_idle();
        host_idle();
        step(); step();
        expect_val(K_OBUS,  "rst_obus",  32'h0);
        expect_val(K_READY, "rst_ready", 32'h1);
        expect_val(K_WAIT,  "rst_wait",  32'h0);
        drain();
        RESET = 1'b0;
        step();

        // Single CPU write, latency 1
        cpu_set(1'b1, 1'b1, 3'd0, 16'hABCD, 16'h00FF);
        #1; expect_val(K_WAIT, "cpu1_wait", 32'h0); drain();
        step(); cpu_idle();
        expect_val(K_OBUS, "cpu1_obus", 32'h000CD); drain();

        // Host write to the partial slice
        host_set(1'b1, 3'd1, 16'hFFFF, 16'h000F);
        step(); host_idle();
        expect_val(K_READY, "host1_busy", 32'h0);
        expect_val(K_OBUS,  "host1_hold", 32'h000CD);
        drain();
        step();
        expect_val(K_READY, "host1_ready", 32'h1);
        expect_val(K_OBUS,  "host1_obus",  32'hF00CD);
        drain();

        // CE low, out-of-range address, zero mask: no change
        cpu_set(1'b0, 1'b1, 3'd0, 16'hFFFF, 16'hFFFF);
        #1; expect_val(K_WAIT, "ce0_wait", 32'h0); drain();
        step(); cpu_idle();
        expect_val(K_OBUS, "ce0_obus", 32'hF00CD); drain();
        cpu_set(1'b1, 1'b1, 3'd5, 16'hFFFF, 16'hFFFF);
        #1; expect_val(K_WAIT, "oor_wait", 32'h0); drain();
        step(); cpu_idle();
        expect_val(K_OBUS, "oor_obus", 32'hF00CD); drain();
        cpu_set(1'b1, 1'b1, 3'd0, 16'hFFFF, 16'h0000);
        #1; expect_val(K_WAIT, "m0_wait", 32'h0); drain();
        step(); cpu_idle();
        expect_val(K_OBUS, "m0_obus", 32'hF00CD); drain();

        // Different slices in the same cycle: both land, rotation kept (CPU last)
        host_set(1'b1, 3'd1, 16'h0000, 16'h000F);
        step(); host_idle();
        cpu_set(1'b1, 1'b1, 3'd0, 16'h1234, 16'hFFFF);
        #1; expect_val(K_WAIT, "dual_wait", 32'h0); drain();
        step(); cpu_idle();
        expect_val(K_OBUS,  "dual_obus",  32'h01234);
        expect_val(K_READY, "dual_ready", 32'h1);
        drain();

        // Conflict with CPU as last grant: host wins
        host_set(1'b1, 3'd0, 16'h5555, 16'hFFFF);
        step(); host_idle();
        cpu_set(1'b1, 1'b1, 3'd0, 16'hAAAA, 16'hFFFF);
        #1; expect_val(K_WAIT, "keep_wait", 32'h1); drain();
        step(); cpu_idle();
        expect_val(K_OBUS,  "keep_obus",  32'h05555);
        expect_val(K_READY, "keep_ready", 32'h1);
        drain();

        // Two different out-of-range addresses conflict; CPU wins this round
        host_set(1'b1, 3'd6, 16'hFFFF, 16'hFFFF);
        step(); host_idle();
        cpu_set(1'b1, 1'b1, 3'd7, 16'hFFFF, 16'hFFFF);
        #1; expect_val(K_WAIT, "oor2_wait", 32'h0); drain();
        step();
        expect_val(K_OBUS,  "oor2_obus",  32'h05555);
        expect_val(K_READY, "oor2_pend",  32'h0);
        drain();
        cpu_set(1'b1, 1'b1, 3'd0, 16'h0F0F, 16'hFFFF);
        #1; expect_val(K_WAIT, "oor3_wait", 32'h0); drain();
        step(); cpu_idle();
        expect_val(K_OBUS,  "oor3_obus",  32'h00F0F);
        expect_val(K_READY, "oor3_ready", 32'h1);
        drain();

        // Reset, then three same-slice conflicts: CPU, host, CPU
        RESET = 1'b1;
        #1;
        expect_val(K_OBUS, "rst2_obus", 32'h0); drain();
        step();
        RESET = 1'b0;
        host_set(1'b1, 3'd0, 16'h2222, 16'hFFFF);
        step(); host_idle();
        cpu_set(1'b1, 1'b1, 3'd0, 16'h1111, 16'hFFFF);
        #1; expect_val(K_WAIT, "c1_wait", 32'h0); drain();
        step();
        expect_val(K_OBUS,  "c1_obus",  32'h01111);
        expect_val(K_READY, "c1_pend",  32'h0);
        drain();
        #1; expect_val(K_WAIT, "c2_wait", 32'h1); drain();
        step(); cpu_idle();
        expect_val(K_OBUS,  "c2_obus",  32'h02222);
        expect_val(K_READY, "c2_ready", 32'h1);
        drain();
        host_set(1'b1, 3'd0, 16'h3333, 16'hFFFF);
        step(); host_idle();
        cpu_set(1'b1, 1'b1, 3'd0, 16'h1111, 16'hFFFF);
        #1; expect_val(K_WAIT, "c3_wait", 32'h0); drain();
        step(); cpu_idle();
        expect_val(K_OBUS, "c3_obus", 32'h01111); drain();
        step();
        expect_val(K_OBUS,  "c3_host_obus", 32'h03333);
        expect_val(K_READY, "c3_ready",     32'h1);
        drain();

        // Asynchronous reset mid-cycle while a host write is pending
        host_set(1'b1, 3'd1, 16'hFFFF, 16'h000F);
        step(); host_idle();
        expect_val(K_READY, "ar_pend", 32'h0); drain();
        #2; RESET = 1'b1;
        #1;
        expect_val(K_OBUS,  "ar_obus",  32'h0);
        expect_val(K_READY, "ar_ready", 32'h1);
        drain();
        @(negedge CLK);
        RESET = 1'b0;
        step(); step();
        expect_val(K_OBUS,  "ar_post_obus",  32'h0);
        expect_val(K_READY, "ar_post_ready", 32'h1);
        expect_val(K_WAIT,  "ar_post_wait",  32'h0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bcpu_obus_arb.md
Name: bcpu_obus_arb

Overview:
Owns the BCPU16 output bus register (OBUS) and shares its single write path between two requesters. One is the barrel pipeline executing OUT Ra, Rb, i3. The other is an external host/debug configuration port with a valid/ready handshake. Each write is a masked slice update, OBUS[slice] = (OBUS[slice] & ~mask) | (data & mask). When both requesters target the same slice, a round-robin arbiter decides; a losing pipeline thread gets WAIT_REQUEST so its instruction repeats on its next barrel slot.

Parameters:
DATA_WIDTH, 16, data/slice width in bits.
BUS_ADDR_WIDTH, 3, width of the bus slice address taken from the instruction i3 field.
OBUS_BITS, 4, output bus width in bits (1..128); the last slice may be partial.

Ports:
CLK  in  1  clock, single clock domain.
RESET  in  1  reset, asynchronous, active-high.
CE  in  1  pipeline step enable; pipeline requests are considered only when 1.
CPU_WR_EN  in  1  stage-2 OUT instruction valid.
CPU_ADDR  in  BUS_ADDR_WIDTH  slice address for the pipeline write.
CPU_DATA  in  DATA_WIDTH  Ra value.
CPU_MASK  in  DATA_WIDTH  Rb value (write mask).
WAIT_REQUEST  out  1  combinational; 1 = pipeline write not taken, repeat the instruction.
HOST_VALID  in  1  host write request.
HOST_READY  out  1  host buffer empty; handshake completes when HOST_VALID & HOST_READY.
HOST_ADDR  in  BUS_ADDR_WIDTH  host slice address.
HOST_DATA  in  DATA_WIDTH  host data.
HOST_MASK  in  DATA_WIDTH  host write mask.
OBUS  out  OBUS_BITS  registered output bus.

Behaviour:
- Slices:
  - NSLICES = ceil(OBUS_BITS/DATA_WIDTH).
  - An address >= NSLICES is a legal no-op write: it is granted and completes, and OBUS is unchanged.
  - For a partial last slice, bits above OBUS_BITS are discarded.
- Host FSM: states H_EMPTY and H_PEND.
  - HOST_READY = (state == H_EMPTY).
  - In H_EMPTY, a handshake captures addr/data/mask into the host buffer and moves to H_PEND.
  - In H_PEND, the buffered write is applied at the edge of the cycle in which it is granted, then the FSM returns to H_EMPTY.
  - The earliest new acceptance is the cycle after that edge, so throughput is at most one host write per 2 cycles.
  - Host buffer processing ignores CE.
- Pipeline request: cpu_req = CE & CPU_WR_EN.
  - If granted, the write is applied at the edge ending the current cycle and is visible in OBUS on the next cycle, giving a latency of 1.
- Arbitration, evaluated each cycle:
  - Only cpu_req, or only H_PEND: that requester is granted.
  - Both, with different effective slices: both are granted and applied at the same edge. The last_grant register is unchanged.
  - Both, with the same slice address: last_grant decides. The winner is the requester not granted last time, and last_grant updates to the winner.
  - A lost cpu_req drives WAIT_REQUEST=1 and leaves OBUS unchanged for that write. A lost host write stays in H_PEND.
  - Two out-of-range addresses count as the same slice.
- WAIT_REQUEST is 0 whenever cpu_req=0. It depends combinationally on CE, CPU_WR_EN, CPU_ADDR, the host FSM state, the host buffer address and last_grant.
- Reset (async, any time, including with H_PEND):
  - OBUS = 0, host FSM = H_EMPTY (HOST_READY=1), host buffer = 0, last_grant = HOST (so the first conflict goes to the CPU).
  - A pending host write is dropped.
  - WAIT_REQUEST is 0 while CPU_WR_EN=0.
- With mask = 0, the write is granted, changes nothing, and still counts for last_grant.

Decomposition:
- bcpu_defs package:
  - GRANT_CPU / GRANT_HOST constants.
  - host FSM state enum (H_EMPTY, H_PEND).
  - helper function obus_slices(OBUS_BITS, DATA_WIDTH).
- One sub-module, bcpu_obus_slice_wr:
  - combinational masked update of one DATA_WIDTH slice given the current value, data, mask and write enable.
  - instantiated per slice for each requester, with the host applied first and the CPU second when the slices differ.

Test Plan:
- Reset, OBUS_BITS=20: OBUS=0, HOST_READY=1. Then CPU write addr 0, data 16'hABCD, mask 16'h00FF, CE=1 -> next cycle OBUS[15:0]=16'h00CD, WAIT_REQUEST=0.
- Host write addr 1, data 16'hFFFF, mask 16'h000F -> HOST_READY=0 for one cycle, then OBUS[19:16]=4'hF and HOST_READY=1.
- Same-slice conflict three consecutive times, addr 0 (CPU data 16'h1111, host 16'h2222, mask 16'hFFFF), right after reset -> CPU wins first (WAIT_REQUEST=0, OBUS[15:0]=16'h1111), host wins second (WAIT_REQUEST=1, OBUS[15:0]=16'h2222), CPU wins third.
- CPU addr 0 and host pending addr 1, same cycle -> both applied at one edge, WAIT_REQUEST=0, last_grant unchanged.
- CPU write with CE=0 -> no change, WAIT_REQUEST=0. CPU write addr 5 with NSLICES=2 -> no change, WAIT_REQUEST=0.
- RESET asserted asynchronously mid-cycle while H_PEND -> OBUS=0 immediately and HOST_READY=1; the pending write is never applied after release.
